// File: rtl/bcd_key_entry.sv
// Debounced 10-key BCD keypad front end with a shifting multi-digit entry register.
// One key press yields one KEY_VLD pulse; debounced multi-key chords yield one ERR pulse instead.
module bcd_key_entry #(
    parameter int DIGITS    = 4,
    parameter int DB_CYCLES = 4
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [9:0]                   D,
    input  logic                         CLR,
    output logic [3:0]                   KEY_BIN,
    output logic                         KEY_VLD,
    output logic                         CHK,
    output logic                         ERR,
    output logic [4*DIGITS-1:0]          VAL,
    output logic [$clog2(DIGITS+1)-1:0]  CNT,
    output logic                         FULL
);

    localparam int VW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [7:0]    DB_LAST = 8'(DB_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t      state_r;
    logic [9:0]  smp_r;
    logic [7:0]  db_cnt_r;

    logic        accept_s;
    logic        key_ok_s;
    logic [3:0]  key_s;
    logic        offer_s;

    function automatic logic is_one_hot(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

    function automatic logic [3:0] encode_key(input logic [9:0] v);
        logic [3:0] k;
        k = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) begin
                k = 4'(i);
            end
        end
        return k;
    endfunction

    // Acceptance edge detection; when accepting, D equals the captured sample so D is decoded directly.
    always_comb begin
        accept_s = 1'b0;
        case (state_r)
            IDLE:     accept_s = (D != 10'd0) && (DB_LAST == 8'd1);
            DEBOUNCE: accept_s = (D == smp_r) && ((db_cnt_r + 8'd1) == DB_LAST);
            default:  accept_s = 1'b0;
        endcase
        key_ok_s = is_one_hot(D);
        key_s    = encode_key(D);
        offer_s  = accept_s && key_ok_s;
    end

    // Debounce FSM with registered key code, pulses and held indication.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r  <= IDLE;
            smp_r    <= 10'd0;
            db_cnt_r <= 8'd0;
            KEY_BIN  <= 4'd0;
            KEY_VLD  <= 1'b0;
            ERR      <= 1'b0;
            CHK      <= 1'b0;
        end else begin
            KEY_VLD <= 1'b0;
            ERR     <= 1'b0;
            if (accept_s) begin
                if (key_ok_s) begin
                    KEY_BIN <= key_s;
                    KEY_VLD <= 1'b1;
                end else begin
                    ERR <= 1'b1;
                end
            end
            case (state_r)
                IDLE: begin
                    if (D != 10'd0) begin
                        smp_r <= D;
                        if (accept_s) begin
                            state_r  <= HELD;
                            db_cnt_r <= 8'd0;
                            CHK      <= 1'b1;
                        end else begin
                            state_r  <= DEBOUNCE;
                            db_cnt_r <= 8'd1;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (D != smp_r) begin
                        state_r  <= IDLE;
                        db_cnt_r <= 8'd0;
                    end else if (accept_s) begin
                        state_r  <= HELD;
                        db_cnt_r <= 8'd0;
                        CHK      <= 1'b1;
                    end else begin
                        db_cnt_r <= db_cnt_r + 8'd1;
                    end
                end
                HELD: begin
                    if (D == 10'd0) begin
                        // The entry edge already counts as the first release sample.
                        if (DB_LAST == 8'd1) begin
                            state_r  <= IDLE;
                            db_cnt_r <= 8'd0;
                            CHK      <= 1'b0;
                        end else begin
                            state_r  <= RELEASE;
                            db_cnt_r <= 8'd1;
                        end
                    end
                end
                RELEASE: begin
                    if (D != 10'd0) begin
                        state_r  <= HELD;
                        db_cnt_r <= 8'd0;
                    end else if ((db_cnt_r + 8'd1) == DB_LAST) begin
                        state_r  <= IDLE;
                        db_cnt_r <= 8'd0;
                        CHK      <= 1'b0;
                    end else begin
                        db_cnt_r <= db_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    db_cnt_r <= 8'd0;
                    CHK      <= 1'b0;
                end
            endcase
        end
    end

    // Entry register: CLR takes effect before a digit offered on the same edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            VAL  <= '0;
            CNT  <= '0;
            FULL <= 1'b0;
        end else if (offer_s && CLR) begin
            VAL  <= VW'(key_s);
            CNT  <= CNT_ONE;
            FULL <= (CNT_MAX == CNT_ONE);
        end else if (offer_s && !FULL) begin
            VAL  <= (VAL << 3'd4) | VW'(key_s);
            CNT  <= CNT + CNT_ONE;
            FULL <= ((CNT + CNT_ONE) == CNT_MAX);
        end else if (CLR) begin
            VAL  <= '0;
            CNT  <= '0;
            FULL <= 1'b0;
        end else begin
            VAL  <= VAL;
            CNT  <= CNT;
            FULL <= FULL;
        end
    end

endmodule

// File: doc/bcd_key_entry.md
BCD_KEY_ENTRY -- requirements
Module: bcd_key_entry

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning BCD digits held in the entry register (legal range 1..8).
REQ-002 SHALL have parameter DB_CYCLES, default 4, meaning consecutive identical samples needed to accept a press or release (legal range 1..255).
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port D  input  10  raw key lines; bit k high = decimal key k pressed.
REQ-006 SHALL have port CLR  input  1  synchronous clear of the entry register.
REQ-007 SHALL have port KEY_BIN  output  4  BCD code of the last accepted key.
REQ-008 SHALL have port KEY_VLD  output  1  one-cycle pulse per accepted key.
REQ-009 SHALL have port CHK  output  1  debounced key-held indication.
REQ-010 SHALL have port ERR  output  1  one-cycle pulse on a debounced multi-key pattern.
REQ-011 SHALL have port VAL  output  4*DIGITS  accumulated BCD number; newest digit in VAL[3:0].
REQ-012 SHALL have port CNT  output  clog2(DIGITS+1)  number of digits currently held.
REQ-013 SHALL have port FULL  output  1  high when CNT equals DIGITS.

Function
REQ-014 SHALL implement FSM states IDLE, DEBOUNCE, HELD, RELEASE, plus a sample register SMP[9:0] and a debounce counter.
REQ-015 IDLE: D==0 stay; D!=0 capture SMP=D, counter=1, go DEBOUNCE (or evaluate immediately per REQ-017 if DB_CYCLES==1).
REQ-016 DEBOUNCE: D!=SMP -> IDLE with counter cleared, no output pulse; D==SMP -> counter+1.
REQ-017 Acceptance at the DB_CYCLES-th consecutive sampling edge with D==SMP (first edge = capture edge): go HELD.
REQ-018 At acceptance, SMP one-hot key k: KEY_BIN<=k, KEY_VLD pulses for exactly one cycle, and the digit is offered to the entry register.
REQ-019 At acceptance, SMP with two or more bits set: ERR pulses one cycle; KEY_BIN, VAL and CNT unchanged.
REQ-020 HELD: D==0 -> RELEASE with counter=1; otherwise stay; changes in D while HELD never create new acceptances.
REQ-021 RELEASE: D!=0 -> HELD; D==0 for DB_CYCLES consecutive sampling edges (counting the entry edge) -> IDLE.
REQ-022 CHK SHALL be high exactly while the state is HELD or RELEASE.
REQ-023 Offered digit while CNT<DIGITS: VAL<={VAL[4*DIGITS-5:0],digit} (DIGITS==1: VAL<=digit), CNT<=CNT+1.
REQ-024 Offered digit while FULL: VAL and CNT unchanged; KEY_VLD still pulses.
REQ-025 CLR without an offered digit: VAL<=0, CNT<=0 on that edge.
REQ-026 CLR on the same edge as an offered digit: VAL<=digit zero-extended, CNT<=1 (CLR applied first).
REQ-027 CLR SHALL NOT affect FSM state, KEY_BIN, CHK or the debounce counter.
REQ-028 All outputs SHALL be registered; KEY_VLD and ERR are never high simultaneously.

Reset
REQ-029 RST_N low SHALL immediately force: state IDLE, SMP=0, counter=0, KEY_BIN=0, KEY_VLD=0, CHK=0, ERR=0, VAL=0, CNT=0, FULL=0.
REQ-030 Reset asserted mid-debounce or mid-hold SHALL discard the pending key; after release a key already held must be fully re-debounced from IDLE before acceptance.

Verification
REQ-031 Defaults; D=0x008 held 6 cycles then 0 -> KEY_VLD one pulse at 4th sampling edge, KEY_BIN=3, VAL=0x0003, CNT=1, CHK high until 4 zero samples.
REQ-032 D=0x020 for 3 cycles, 0 for 1, 0x020 for 4 -> one KEY_VLD only (after the second run), KEY_BIN=5.
REQ-033 Keys 1,2,3,4,5 pressed/released in order, DIGITS=4 -> VAL=0x1234, FULL=1 after key 4; key 5 gives KEY_VLD, KEY_BIN=5, VAL unchanged.
REQ-034 D=0x006 stable 4 cycles -> ERR one pulse, no KEY_VLD, VAL/CNT unchanged, CHK=1.
REQ-035 CLR asserted on the acceptance edge of key 7 with VAL=0x0012 -> VAL=0x0007, CNT=1.
REQ-036 RST_N pulsed low while key 9 in HELD, key still pressed -> outputs zero; re-acceptance only after 4 stable samples post-reset.
